bram_chain_rx_checker: RTL and testbench
========================================

// Module: bram_chain_rx_checker
// PURPOSE
//  Receive-side checker for the BRAM daisy-chain stress path. Sits at the chain
//  tail and consumes the 36-bit stream emitted by the last stage. It locks to a
//  PRBS-36 pattern, counts word and bit-pattern errors, and captures the first
//  failing word. It also measures toggle activity (bits flipped per word) over a
//  fixed window, so toggle-rate settings can be confirmed on silicon.
// PARAMETERS
//  DATAWIDTH   36    stream width; fixed at 36 for the PRBS polynomial
//  SYNC_WORDS  8     consecutive correct predictions required to declare lock
//  ERR_LIMIT   4     consecutive mismatches in LOCKED that declare loss of lock
//  WINDOW      100   accepted words per toggle-measurement window (>=2)
//  SUM_W       16    toggle_sum width; must hold 36*WINDOW
// PORTS
//  clk               in   1   single clock
//  irst              in   1   synchronous active-high reset
//  en                in   1   checker enable; low forces IDLE
//  clear             in   1   1-cycle pulse: zero counters, sticky flags, capture
//  din_valid         in   1   din carries a word this cycle
//  din               in   36  tail data from the chain
//  locked            out  1   state == LOCKED
//  lost              out  1   sticky: lock was lost at least once
//  err_cnt           out  16  mismatching words while LOCKED, saturating
//  word_cnt          out  32  words accepted while LOCKED, wraps
//  first_err_valid   out  1   sticky: first_err_* hold a capture
//  first_err_data    out  36  received word at first LOCKED mismatch
//  first_err_exp     out  36  expected word at that mismatch
//  toggle_sum        out  SUM_W  popcount(din^prev) summed over the last window
//  toggle_valid      out  1   1-cycle pulse when toggle_sum updates
// BEHAVIOUR
//  - Reset: registers are sampled on posedge clk with irst high. All outputs are 0
//    and the state is IDLE. Reset mid-operation discards the seed and all counts.
//  - PRBS next(x) = {x[34:0], x[35]^x[24]}, which is x^36+x^25+1.
//  - A word is accepted only when din_valid=1 in SYNC or LOCKED. Outputs are
//    registered, so each status update appears on the cycle after the word.
//  - FSM IDLE: wait for en=1 -> SYNC. In any state, en=0 -> IDLE on the next
//    cycle; counters and captures hold their values.
//  - FSM SYNC:
//      first accepted word seeds exp=next(din), sync_cnt=0.
//      Match increments sync_cnt. Mismatch reseeds from din and sets sync_cnt=0.
//      An all-zero din never seeds and never counts as a match.
//      Go to LOCKED on the accepted word that makes sync_cnt==SYNC_WORDS.
//  - FSM LOCKED: every accepted word increments word_cnt.
//      Mismatch: err_cnt+1, saturating at 16'hFFFF; consec_err+1. If
//      first_err_valid=0, capture din/exp and set first_err_valid.
//      Match sets consec_err=0.
//      exp always advances from exp, never from din, so a single corrupt word
//      counts exactly one error.
//      consec_err reaching ERR_LIMIT: set lost; go to SYNC with the seed cleared.
//  - Toggle meter, active in SYNC/LOCKED:
//      prev holds the last accepted word.
//      The first accepted word after entering SYNC only loads prev.
//      Each later accepted word adds popcount(din^prev) to acc. win_cnt counts
//      from 0 to WINDOW-1.
//      On the WINDOW-th add: toggle_sum <= acc + that add; toggle_valid=1 for one
//      cycle; acc and win_cnt restart at 0.
//      Leaving to IDLE drops the partial window and invalidates prev.
//  - clear: zeroes err_cnt, word_cnt, lost, first_err_*, toggle_sum, acc and
//    win_cnt. FSM state and seed are unchanged. clear and a mismatch in the same
//    cycle: clear wins and that error is not counted.
//  - din_valid=0: no state or counter changes.
// TESTING
//  1 PRBS from seed 36'h0_0000_0001, continuous valid -> locked=1 on the cycle
//    after the 9th word; err_cnt=0; word_cnt increments by 1 per word.
//  2 After lock, flip bit 0 of one word -> err_cnt=1, first_err_valid=1,
//    first_err_data=corrupt word, first_err_exp=clean word, locked stays 1.
//  3 After lock, 4 consecutive wrong words -> lost=1, locked=0; clean PRBS
//    resumes -> relock after 9 words; err_cnt=4.
//  4 Stream alternating 36'hb_cbcb_cbcb / ~36'hb_cbcb_cbcb with WINDOW=100 ->
//    toggle_valid pulses every 100 words after the first; toggle_sum=3600.
//  5 err_cnt preset by forcing 16'hFFFF, then one mismatch -> stays 16'hFFFF.
//    clear in the same cycle as a mismatch -> err_cnt=0.
//  6 irst high for 1 cycle while LOCKED -> all outputs 0, state IDLE.
//    With en held high: SYNC, then lock again after 9 words.

Source files
------------

// File: rtl/bram_chain_rx_checker_if.sv
// Tail-of-chain data stream: the last BRAM stage drives it and the checker consumes it.
interface bram_chain_rx_checker_if #(
  parameter int DATAWIDTH = 36
);
  logic                 din_valid;
  logic [DATAWIDTH-1:0] din;

  modport master (output din_valid, din);
  modport slave  (input  din_valid, din);
endinterface

// File: rtl/bram_chain_rx_checker.sv
// PRBS-36 receive checker for the BRAM daisy chain: lock/loss FSM, error counting,
// first-failure capture and a windowed toggle-activity meter.
module bram_chain_rx_checker #(
  parameter int DATAWIDTH  = 36,
  parameter int SYNC_WORDS = 8,
  parameter int ERR_LIMIT  = 4,
  parameter int WINDOW     = 100,
  parameter int SUM_W      = 16
) (
  input  logic                  clk,
  input  logic                  irst,
  input  logic                  en,
  input  logic                  clear,
  bram_chain_rx_checker_if.slave rx,
  output logic                  locked,
  output logic                  lost,
  output logic [15:0]           err_cnt,
  output logic [31:0]           word_cnt,
  output logic                  first_err_valid,
  output logic [DATAWIDTH-1:0]  first_err_data,
  output logic [DATAWIDTH-1:0]  first_err_exp,
  output logic [SUM_W-1:0]      toggle_sum,
  output logic                  toggle_valid
);

  localparam int SC_W = $clog2(SYNC_WORDS + 1);
  localparam int CE_W = $clog2(ERR_LIMIT + 1);
  localparam int WC_W = $clog2(WINDOW);
  localparam int PC_W = $clog2(DATAWIDTH + 1);

  typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;

  state_t               state, state_next;
  logic                 seeded;
  logic [DATAWIDTH-1:0] exp_word;
  logic [SC_W-1:0]      sync_cnt;
  logic [CE_W-1:0]      consec_err;
  logic [DATAWIDTH-1:0] prev;
  logic                 prev_valid;
  logic [SUM_W-1:0]     acc;
  logic [WC_W-1:0]      win_cnt;

  logic                 accept, match, din_zero, sync_hit, sync_done, lock_fail;
  logic [PC_W-1:0]      tog_add;

  // x^36 + x^25 + 1
  function automatic logic [DATAWIDTH-1:0] prbs_next(input logic [DATAWIDTH-1:0] x);
    return {x[DATAWIDTH-2:0], x[35] ^ x[24]};
  endfunction

  assign accept    = rx.din_valid && en && (state != IDLE);
  assign match     = (rx.din == exp_word);
  assign din_zero  = (rx.din == '0);
  assign sync_hit  = seeded && match && !din_zero;
  assign sync_done = sync_hit && (sync_cnt == SC_W'(SYNC_WORDS - 1));
  assign lock_fail = !match && (consec_err == CE_W'(ERR_LIMIT - 1));
  assign tog_add   = PC_W'($countones(rx.din ^ prev));
  assign locked    = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (irst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: state_next gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = SYNC;
      SYNC:    if (!en) state_next = IDLE;
               else if (accept && sync_done) state_next = LOCKED;
      LOCKED:  if (!en) state_next = IDLE;
               else if (accept && lock_fail) state_next = SYNC;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: later non-blocking assignments override earlier ones in this block, so the
  // loss-of-lock and clear branches deliberately come after the normal updates.
  always_ff @(posedge clk) begin
    if (irst) begin
      seeded          <= 1'b0;
      exp_word        <= '0;
      sync_cnt        <= '0;
      consec_err      <= '0;
      prev            <= '0;
      prev_valid      <= 1'b0;
      acc             <= '0;
      win_cnt         <= '0;
      lost            <= 1'b0;
      err_cnt         <= '0;
      word_cnt        <= '0;
      first_err_valid <= 1'b0;
      first_err_data  <= '0;
      first_err_exp   <= '0;
      toggle_sum      <= '0;
      toggle_valid    <= 1'b0;
    end else begin
      toggle_valid <= 1'b0;
      if (!en) begin
        seeded     <= 1'b0;
        sync_cnt   <= '0;
        consec_err <= '0;
        prev_valid <= 1'b0;
        acc        <= '0;
        win_cnt    <= '0;
      end else if (accept) begin
        prev       <= rx.din;
        prev_valid <= 1'b1;
        if (prev_valid) begin
          if (win_cnt == WC_W'(WINDOW - 1)) begin
            toggle_sum   <= acc + SUM_W'(tog_add);
            toggle_valid <= 1'b1;
            acc          <= '0;
            win_cnt      <= '0;
          end else begin
            acc     <= acc + SUM_W'(tog_add);
            win_cnt <= win_cnt + 1'b1;
          end
        end

        case (state)
          SYNC: begin
            if (sync_hit) begin
              exp_word   <= prbs_next(exp_word);
              sync_cnt   <= sync_cnt + 1'b1;
              consec_err <= '0;
            end else begin
              // An all-zero word is the PRBS lockup state: it must never seed.
              seeded   <= !din_zero;
              exp_word <= prbs_next(rx.din);
              sync_cnt <= '0;
            end
          end
          LOCKED: begin
            word_cnt <= word_cnt + 32'd1;
            exp_word <= prbs_next(exp_word);
            if (match) begin
              consec_err <= '0;
            end else begin
              if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
              consec_err <= consec_err + 1'b1;
              if (!first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_data  <= rx.din;
                first_err_exp   <= exp_word;
              end
              if (lock_fail) begin
                lost       <= 1'b1;
                seeded     <= 1'b0;
                sync_cnt   <= '0;
                consec_err <= '0;
                prev_valid <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end

      if (clear) begin
        err_cnt         <= '0;
        word_cnt        <= '0;
        lost            <= 1'b0;
        first_err_valid <= 1'b0;
        first_err_data  <= '0;
        first_err_exp   <= '0;
        toggle_sum      <= '0;
        toggle_valid    <= 1'b0;
        acc             <= '0;
        win_cnt         <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bram_chain_rx_checker.sv
// Directed bench for bram_chain_rx_checker: lock, errors, loss/relock, saturation,
// clear priority, reset and the toggle meter.
module tb_bram_chain_rx_checker;

  logic        clk;
  logic        irst;
  logic        en;
  logic        clear;
  logic        locked, lost, first_err_valid, toggle_valid;
  logic [15:0] err_cnt;
  logic [31:0] word_cnt;
  logic [35:0] first_err_data, first_err_exp;
  logic [15:0] toggle_sum;

  int errors = 0;
  int checks = 0;

  bram_chain_rx_checker_if #(.DATAWIDTH(36)) rx_if ();

  bram_chain_rx_checker dut (
    .clk             (clk),
    .irst            (irst),
    .en              (en),
    .clear           (clear),
    .rx              (rx_if),
    .locked          (locked),
    .lost            (lost),
    .err_cnt         (err_cnt),
    .word_cnt        (word_cnt),
    .first_err_valid (first_err_valid),
    .first_err_data  (first_err_data),
    .first_err_exp   (first_err_exp),
    .toggle_sum      (toggle_sum),
    .toggle_valid    (toggle_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [35:0] nx(input logic [35:0] v);
    return {v[34:0], v[35] ^ v[24]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [35:0] w);
    rx_if.din_valid = 1'b1;
    rx_if.din       = w;
    @(negedge clk);
    rx_if.din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_if.din_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [35:0] x;
    logic [35:0] saved_bad;
    logic [35:0] tog_a;
    int          pulses;

    irst = 1'b1; en = 1'b0; clear = 1'b0;
    rx_if.din_valid = 1'b0; rx_if.din = '0;
    repeat (2) @(negedge clk);
    irst = 1'b0;
    check("rst_locked", locked, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_first_err_valid", first_err_valid, 0);
    check("rst_toggle_sum", toggle_sum, 0);

    // Lock on PRBS from seed 1
    en = 1'b1;
    idle(1);
    x = 36'h0_0000_0001;
    for (int i = 0; i < 8; i++) begin
      send(x);
      x = nx(x);
    end
    check("t1_not_locked_after_8", locked, 0);
    send(x); x = nx(x);
    check("t1_locked_after_9", locked, 1);
    check("t1_word_cnt_at_lock", word_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      send(x); x = nx(x);
    end
    check("t1_word_cnt_3", word_cnt, 3);
    check("t1_err_cnt", err_cnt, 0);

    // Single corrupt word
    send(x ^ 36'h1);
    check("t2_err_cnt", err_cnt, 1);
    check("t2_first_err_valid", first_err_valid, 1);
    check("t2_first_err_data", first_err_data, x ^ 36'h1);
    check("t2_first_err_exp", first_err_exp, x);
    check("t2_locked", locked, 1);
    x = nx(x);
    send(x); x = nx(x);
    check("t2_err_cnt_after_clean", err_cnt, 1);
    check("t2_word_cnt", word_cnt, 5);
    idle(3);
    check("t2_word_cnt_gap", word_cnt, 5);

    // Loss of lock and relock
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    check("t3_clear_err_cnt", err_cnt, 0);
    check("t3_clear_word_cnt", word_cnt, 0);
    check("t3_clear_first_err_valid", first_err_valid, 0);
    saved_bad = ~x;
    for (int i = 0; i < 3; i++) begin
      send(~x); x = nx(x);
    end
    check("t3_locked_after_3_bad", locked, 1);
    check("t3_err_cnt_3", err_cnt, 3);
    send(~x); x = nx(x);
    check("t3_lost", lost, 1);
    check("t3_locked_dropped", locked, 0);
    check("t3_err_cnt_4", err_cnt, 4);
    check("t3_word_cnt_4", word_cnt, 4);
    check("t3_first_err_data", first_err_data, saved_bad);
    for (int i = 0; i < 8; i++) begin
      send(x); x = nx(x);
    end
    check("t3_not_relocked_after_8", locked, 0);
    send(x); x = nx(x);
    check("t3_relocked_after_9", locked, 1);
    check("t3_err_cnt_held", err_cnt, 4);
    check("t3_lost_sticky", lost, 1);

    // Saturation and clear priority
    force dut.err_cnt = 16'hFFFF;
    idle(1);
    release dut.err_cnt;
    send(~x); x = nx(x);
    check("t5_err_cnt_saturated", err_cnt, 16'hFFFF);
    check("t5_first_err_data_kept", first_err_data, saved_bad);
    send(x); x = nx(x);
    clear = 1'b1;
    send(~x); x = nx(x);
    clear = 1'b0;
    check("t5_clear_beats_error", err_cnt, 0);
    check("t5_clear_no_capture", first_err_valid, 0);
    check("t5_clear_lost", lost, 0);
    check("t5_still_locked", locked, 1);
    send(x); x = nx(x);

    // Reset while locked
    irst = 1'b1;
    idle(1);
    irst = 1'b0;
    check("t6_locked", locked, 0);
    check("t6_word_cnt", word_cnt, 0);
    check("t6_first_err_exp", first_err_exp, 0);
    check("t6_lost", lost, 0);
    idle(1);
    x = 36'h8_1234_5678;
    for (int i = 0; i < 8; i++) begin
      send(x); x = nx(x);
    end
    check("t6_not_locked_after_8", locked, 0);
    send(x); x = nx(x);
    check("t6_relocked", locked, 1);
    for (int i = 0; i < 3; i++) begin
      send(x); x = nx(x);
    end
    check("t6_word_cnt_3", word_cnt, 3);
    check("t6_err_cnt", err_cnt, 0);

    // en low forces IDLE, counters hold
    en = 1'b0;
    idle(2);
    check("en_low_locked", locked, 0);
    check("en_low_word_cnt_held", word_cnt, 3);

    // Toggle meter
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    en = 1'b1;
    idle(1);
    tog_a = 36'hb_cbcb_cbcb;
    pulses = 0;
    send(tog_a);
    for (int i = 1; i < 100; i++) begin
      send((i % 2) ? ~tog_a : tog_a);
      if (toggle_valid) pulses++;
    end
    check("t4_no_early_pulse", pulses, 0);
    send(tog_a);
    check("t4_pulse_1", toggle_valid, 1);
    check("t4_sum_1", toggle_sum, 16'd3600);
    pulses = 0;
    for (int i = 101; i < 200; i++) begin
      send((i % 2) ? ~tog_a : tog_a);
      if (toggle_valid) pulses++;
    end
    check("t4_no_mid_pulse", pulses, 0);
    send(tog_a);
    check("t4_pulse_2", toggle_valid, 1);
    check("t4_sum_2", toggle_sum, 16'd3600);
    idle(1);
    check("t4_pulse_one_cycle", toggle_valid, 0);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    check("t4_clear_sum", toggle_sum, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
